// File: rtl/base_stream_realign.sv
// Removes a per-packet leading byte offset from a valid/ready beat stream and
// repacks the remaining bytes into full beats (byte 0 is the most significant byte).
`timescale 1ns/1ps
module base_stream_realign #(
  parameter int bytes  = 16,
  parameter int width  = bytes * 8,
  parameter int swidth = $clog2(bytes)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_v,
  output logic              i_r,
  input  logic [width-1:0]  i_d,
  input  logic              i_e,
  input  logic [swidth:0]   i_bc,
  input  logic [swidth-1:0] i_ofst,
  output logic              o_v,
  input  logic              o_r,
  output logic [width-1:0]  o_d,
  output logic              o_e,
  output logic [swidth:0]   o_bc,
  output logic              o_perr,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a beat moves on a port in every cycle where its valid and ready are
  // both high at the rising clock edge; valid never depends combinationally on ready.
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

  localparam int              SHW    = swidth + 4;
  localparam logic [SHW-1:0]  WBITS  = SHW'(width);
  localparam logic [swidth:0] NBYTES = (swidth + 1)'(bytes);

  state_t              state_q, state_d;
  logic [width-1:0]    hold_q, hold_d;
  logic [swidth-1:0]   ofst_q, ofst_d;
  logic [swidth:0]     res_q, res_d;
  logic                o_v_q, o_v_d;
  logic [width-1:0]    o_d_q, o_d_d;
  logic                o_e_q, o_e_d;
  logic [swidth:0]     o_bc_q, o_bc_d;
  logic                perr_q, perr_d;

  logic                out_free, accept, emit, emit_e;
  logic [width-1:0]    emit_data;
  logic [swidth:0]     emit_bc;

  // Joins the tail of the held beat with the head of the current one; a zero offset
  // shifts the current beat by the full width, which yields zero.
  function automatic logic [width-1:0] join_beats(input logic [width-1:0]  h,
                                                  input logic [width-1:0]  c,
                                                  input logic [swidth-1:0] n);
    logic [SHW-1:0] sh;
    sh = {1'b0, n, 3'b000};
    return (h << sh) | (c >> (WBITS - sh));
  endfunction

  function automatic logic [width-1:0] keep_bytes(input logic [width-1:0] d,
                                                  input logic [swidth:0]  bc);
    return d & ~({width{1'b1}} >> {bc, 3'b000});
  endfunction

  assign out_free = ~o_v_q | o_r;
  assign i_r      = out_free & (state_q != FLUSH);
  assign accept   = i_v & i_r;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    ofst_d    = ofst_q;
    res_d     = res_q;
    o_v_d     = o_v_q & ~o_r;
    o_d_d     = o_d_q;
    o_e_d     = o_e_q;
    o_bc_d    = o_bc_q;
    perr_d    = 1'b0;
    emit      = 1'b0;
    emit_e    = 1'b0;
    emit_bc   = '0;
    emit_data = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ofst_d = i_ofst;
          if (!i_e) begin
            hold_d  = i_d;
            state_d = HOLD;
          end else if (i_bc > {1'b0, i_ofst}) begin
            emit      = 1'b1;
            emit_data = join_beats(i_d, '0, i_ofst);
            emit_bc   = i_bc - {1'b0, i_ofst};
            emit_e    = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          emit      = 1'b1;
          emit_data = join_beats(hold_q, i_d, ofst_q);
          emit_bc   = NBYTES;
          if (!i_e) begin
            hold_d = i_d;
          end else if (i_bc <= {1'b0, ofst_q}) begin
            emit_bc = NBYTES - {1'b0, ofst_q} + i_bc;
            emit_e  = 1'b1;
            state_d = IDLE;
          end else begin
            hold_d  = i_d;
            res_d   = i_bc - {1'b0, ofst_q};
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_data = join_beats(hold_q, '0, ofst_q);
          emit_bc   = res_q;
          emit_e    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      o_v_d  = 1'b1;
      o_d_d  = keep_bytes(emit_data, emit_bc);
      o_e_d  = emit_e;
      o_bc_d = emit_bc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ofst_q  <= '0;
      res_q   <= '0;
      o_v_q   <= 1'b0;
      o_d_q   <= '0;
      o_e_q   <= 1'b0;
      o_bc_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ofst_q  <= ofst_d;
      res_q   <= res_d;
      o_v_q   <= o_v_d;
      o_d_q   <= o_d_d;
      o_e_q   <= o_e_d;
      o_bc_q  <= o_bc_d;
      perr_q  <= perr_d;
    end
  end

  assign o_v         = o_v_q;
  assign o_d         = o_d_q;
  assign o_e         = o_e_q;
  assign o_bc        = o_bc_q;
  assign o_perr      = perr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_base_stream_realign.sv
// Directed bench for base_stream_realign with 4-byte beats; expected output beats are
// queued as stimulus is issued and a negedge monitor pops them on every output transfer.
`timescale 1ns/1ps
module tb_base_stream_realign;
  localparam int BYTES = 4;
  localparam int W     = 32;
  localparam int SW    = 2;
  localparam int EW    = 1 + (SW + 1) + W;

  logic          clk, reset;
  logic          i_v, i_r, i_e, o_v, o_r, o_e, o_perr;
  logic [W-1:0]  i_d, o_d;
  logic [SW:0]   i_bc, o_bc;
  logic [SW-1:0] i_ofst;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_item;
  int            total = 0;
  int            bad   = 0;
  logic          perr_exp = 1'b0;

  base_stream_realign #(.bytes(BYTES)) dut (
    .clk(clk), .reset(reset),
    .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_e(i_e), .i_bc(i_bc), .i_ofst(i_ofst),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_e(o_e), .o_bc(o_bc), .o_perr(o_perr),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic e, input logic [SW:0] bc, input logic [W-1:0] d);
    exp_q.push_back({e, bc, d});
  endtask

  // Presents one beat and returns just after the clock edge that accepted it.
  task automatic send_beat(input logic [W-1:0] d, input logic e, input logic [SW:0] bc,
                           input logic [SW-1:0] ofst);
    bit acc;
    acc    = 1'b0;
    i_v    = 1'b1;
    i_d    = d;
    i_e    = e;
    i_bc   = bc;
    i_ofst = ofst;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = i_r;
      @(posedge clk);
      #1;
    end
    check("accept", acc, 1);
  endtask

  task automatic idle();
    i_v = 1'b0;
    i_e = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("o_perr", o_perr, perr_exp);
      if (o_v && o_r) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h want none", {o_e, o_bc, o_d});
        end else begin
          exp_item = exp_q.pop_front();
          check("out_beat", {o_e, o_bc, o_d}, exp_item);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; i_v = 1'b0; i_d = '0; i_e = 1'b0; i_bc = '0; i_ofst = '0; o_r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_v", o_v, 0);
    check("rst_o_e", o_e, 0);
    check("rst_o_perr", o_perr, 0);
    check("rst_o_d", o_d, 0);
    check("rst_o_bc", o_bc, 0);
    check("rst_state", dbg_state, 0);
    check("rst_i_r", i_r, 1);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // T1: zero offset, single beat
    push_exp(1'b1, 3'd4, 32'h11223344);
    send_beat(32'h11223344, 1'b1, 3'd4, 2'd0);
    idle();

    // T2: offset 1 spills into a flush beat; offset on later beat is ignored
    push_exp(1'b0, 3'd4, 32'h11223344);
    push_exp(1'b1, 3'd3, 32'h55667700);
    send_beat(32'h00112233, 1'b0, 3'd0, 2'd1);
    send_beat(32'h44556677, 1'b1, 3'd4, 2'd3);
    idle();

    // T3: offset 3, short last beat merges without flush; don't-care bytes masked
    push_exp(1'b1, 3'd3, 32'h01020300);
    send_beat(32'hAABBCC01, 1'b0, 3'd0, 2'd3);
    send_beat(32'h0203FFFF, 1'b1, 3'd2, 2'd0);
    idle();

    // T4: nothing left after offset -> one-cycle error pulse, then a normal packet
    send_beat(32'hCAFEF00D, 1'b1, 3'd2, 2'd2);
    perr_exp = 1'b1;
    idle();
    @(posedge clk); #1;
    perr_exp = 1'b0;
    push_exp(1'b1, 3'd3, 32'hADBEEF00);
    send_beat(32'hDEADBEEF, 1'b1, 3'd4, 2'd1);
    idle();

    // T5: stall the first output beat, then an immediate two-beat zero-offset packet
    push_exp(1'b0, 3'd4, 32'h11223344);
    push_exp(1'b1, 3'd3, 32'h55667700);
    push_exp(1'b0, 3'd4, 32'hA1A2A3A4);
    push_exp(1'b1, 3'd2, 32'hB1B20000);
    send_beat(32'h00112233, 1'b0, 3'd0, 2'd1);
    o_r = 1'b0;
    send_beat(32'h44556677, 1'b1, 3'd4, 2'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_o_v", o_v, 1);
      check("stall_o_d", o_d, 32'h11223344);
      check("stall_o_e", o_e, 0);
      check("stall_i_r", i_r, 0);
      @(posedge clk); #1;
    end
    o_r = 1'b1;
    send_beat(32'hA1A2A3A4, 1'b0, 3'd0, 2'd0);
    send_beat(32'hB1B2B3B4, 1'b1, 3'd2, 2'd0);
    idle();

    // T6: reset in HOLD, then in FLUSH, then a clean packet
    send_beat(32'h00112233, 1'b0, 3'd0, 2'd1);
    idle();
    @(negedge clk);
    check("hold_state", dbg_state, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_hold_state", dbg_state, 0);
    check("rst_hold_o_v", o_v, 0);
    @(negedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    o_r = 1'b0;
    send_beat(32'h00112233, 1'b0, 3'd0, 2'd1);
    send_beat(32'h44556677, 1'b1, 3'd4, 2'd1);
    idle();
    @(negedge clk);
    check("flush_state", dbg_state, 2);
    check("flush_o_v", o_v, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_flush_o_v", o_v, 0);
    check("rst_flush_state", dbg_state, 0);
    check("rst_flush_o_e", o_e, 0);
    @(negedge clk); #2 reset = 1'b0;
    o_r = 1'b1;
    @(posedge clk); #1;

    push_exp(1'b0, 3'd4, 32'h11223344);
    push_exp(1'b1, 3'd3, 32'h55667700);
    send_beat(32'h00112233, 1'b0, 3'd0, 2'd1);
    send_beat(32'h44556677, 1'b1, 3'd4, 2'd1);
    idle();

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
